key_debounce_multi: RTL

//  N-channel key debouncer; successor to the single-key edge debouncer, generalised in channel count, polarity and filter length.
//  Per channel: 2-FF synchroniser, stable-level debounce counter, debounced level plus one-cycle press/release pulses.

---
 rtl/key_debounce_multi.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/key_debounce_multi.sv
// N-channel key debouncer: 2-FF synchroniser, stable-level counter, debounced level and press/release pulses.
// Optional auto-repeat pulses are built only when the macro KEY_REPEAT_EN is defined.
module key_debounce_multi #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 10000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat,
    output logic                key_any
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic              REL_LVL = ACTIVE_LOW ? 1'b1 : 1'b0;

    if (NUM_KEYS < 1) begin : g_bad_num_keys
        $error("NUM_KEYS must be at least 1");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    logic [NUM_KEYS-1:0]            sync1_q;
    logic [NUM_KEYS-1:0]            sync2_q;
    logic [NUM_KEYS-1:0]            pressed_s;
    logic [NUM_KEYS-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_KEYS-1:0][CNT_W-1:0] cnt_d;
    logic [NUM_KEYS-1:0]            state_q;
    logic [NUM_KEYS-1:0]            state_d;
    logic [NUM_KEYS-1:0]            press_q;
    logic [NUM_KEYS-1:0]            press_d;
    logic [NUM_KEYS-1:0]            release_q;
    logic [NUM_KEYS-1:0]            release_d;
    logic [NUM_KEYS-1:0]            accept;
    logic                           any_q;

    // Normalise synchronised level so that 1 always means pressed
    assign pressed_s = ACTIVE_LOW ? ~sync2_q : sync2_q;

    always_comb begin
        cnt_d     = '0;
        state_d   = state_q;
        press_d   = '0;
        release_d = '0;
        accept    = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (pressed_s[i] != state_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    accept[i]    = 1'b1;
                    state_d[i]   = pressed_s[i];
                    press_d[i]   = pressed_s[i];
                    release_d[i] = ~pressed_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= {NUM_KEYS{REL_LVL}};
            sync2_q   <= {NUM_KEYS{REL_LVL}};
            cnt_q     <= '0;
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            any_q     <= 1'b0;
        end else begin
            sync1_q   <= key;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            any_q     <= |state_d;
        end
    end

    assign key_state   = state_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_any     = any_q;

`ifdef KEY_REPEAT_EN
    localparam int                RMAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int                RCNT_W  = $clog2(RMAX + 1);
    localparam logic [RCNT_W-1:0] RD_LAST = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RP_LAST = RCNT_W'(REPEAT_PERIOD - 1);

    logic [NUM_KEYS-1:0][RCNT_W-1:0] rcnt_q;
    logic [NUM_KEYS-1:0][RCNT_W-1:0] rcnt_d;
    logic [NUM_KEYS-1:0]             rstarted_q;
    logic [NUM_KEYS-1:0]             rstarted_d;
    logic [NUM_KEYS-1:0]             repeat_q;
    logic [NUM_KEYS-1:0]             repeat_d;

    // Count only while held and not releasing; the first interval uses the delay, later ones the period
    always_comb begin
        rcnt_d     = '0;
        rstarted_d = '0;
        repeat_d   = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (state_q[i] && !accept[i]) begin
                rstarted_d[i] = rstarted_q[i];
                if (rcnt_q[i] == (rstarted_q[i] ? RP_LAST : RD_LAST)) begin
                    repeat_d[i]   = 1'b1;
                    rstarted_d[i] = 1'b1;
                end else begin
                    rcnt_d[i] = rcnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt_q     <= '0;
            rstarted_q <= '0;
            repeat_q   <= '0;
        end else begin
            rcnt_q     <= rcnt_d;
            rstarted_q <= rstarted_d;
            repeat_q   <= repeat_d;
        end
    end

    assign key_repeat = repeat_q;
`else
    assign key_repeat = '0;
`endif

endmodule
